// File: rtl/basic_handshake_completer.sv
// rtl/basic_handshake_completer.sv - valid/busy handshake receiver: capture FIFO, registered busy, fixed-latency processing FSM
module basic_handshake_completer #(
    parameter int DSIZE       = 4,
    parameter int DEPTH       = 4,
    parameter int PROC_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     valid_in,
    input  logic [DSIZE-1:0]         data_in,
    output logic                     busy,
    output logic                     valid_out,
    output logic [DSIZE-1:0]         data_out,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (PROC_CYCLES > 1) ? $clog2(PROC_CYCLES) : 1;

    localparam logic [LW-1:0] LEVEL_FULL     = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_BUSY     = LW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_LAST       = CW'(PROC_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;

    logic [DSIZE-1:0]  mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [DSIZE-1:0]  work;

    logic              pop;
    logic              push;
    logic              drop;
    logic [LW-1:0]     level_next;

    // FIFO control: the FSM pops only from IDLE; a push at full is legal only when it coincides with a pop
    always_comb begin
        pop        = (state == IDLE) && (level != '0);
        push       = valid_in && ((level != LEVEL_FULL) || pop);
        drop       = valid_in && !push;
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    // FIFO storage carries no reset; only pointers and level define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= data_in;
        end
    end

    // Pointers, occupancy, busy and the sticky overflow flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            level <= level_next;
            // one slot stays reserved for the word already in flight when the requester sees busy
            busy  <= (level_next >= LEVEL_BUSY);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Processing FSM next-state and counter logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    state_next = PROC;
                    cnt_next   = '0;
                end
            end
            PROC: begin
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // FSM state, work register and registered completion outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (pop) begin
                work <= mem[rptr];
            end
            // valid_out is high exactly while the FSM sits in DONE
            valid_out <= (state_next == DONE);
            if (state_next == DONE) begin
                data_out <= work;
            end
        end
    end

endmodule

// File: tb/tb_basic_handshake_completer.sv
// tb/tb_basic_handshake_completer.sv - scoreboard bench for basic_handshake_completer
module tb_basic_handshake_completer;

    localparam int DSIZE       = 4;
    localparam int DEPTH       = 4;
    localparam int PROC_CYCLES = 3;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   valid_in = 1'b0;
    logic [DSIZE-1:0]       data_in = '0;
    logic                   busy;
    logic                   valid_out;
    logic [DSIZE-1:0]       data_out;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;

    basic_handshake_completer #(
        .DSIZE(DSIZE), .DEPTH(DEPTH), .PROC_CYCLES(PROC_CYCLES)
    ) dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in), .data_in(data_in),
        .busy(busy), .valid_out(valid_out), .data_out(data_out),
        .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DSIZE-1:0] d;
        int               due;
    } exp_t;

    // reference model state: queued words, expected completions, processor occupancy timer
    logic [DSIZE-1:0] fq[$];
    exp_t             eq[$];
    logic [DSIZE-1:0] got_q[$];
    int               proc_left = 0;
    int               cyc = 0;
    logic             ovf_m = 1'b0;
    logic [DSIZE-1:0] last_out = '0;
    logic             busy_seen = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: processor takes one queued word when free and is then occupied PROC_CYCLES+2 cycles
    always @(posedge clk) begin
        logic pop_m;
        logic push_m;
        cyc++;
        if (rstn) begin
            if (eq.size() > 0 && eq[0].due == cyc) begin
                last_out = eq[0].d;
            end
            pop_m  = (proc_left == 0) && (fq.size() > 0);
            push_m = valid_in && ((fq.size() < DEPTH) || pop_m);
            if (pop_m) begin
                eq.push_back('{d: fq.pop_front(), due: cyc + PROC_CYCLES});
                proc_left = PROC_CYCLES + 1;
            end else if (proc_left > 0) begin
                proc_left--;
            end
            if (push_m) begin
                fq.push_back(data_in);
            end else if (valid_in) begin
                ovf_m = 1'b1;
            end
        end
    end

    // reset discards everything the model holds
    always @(negedge rstn) begin
        fq.delete();
        eq.delete();
        proc_left = 0;
        ovf_m     = 1'b0;
        last_out  = '0;
    end

    // monitor: compare status every cycle and pop the scoreboard on each completion
    always @(negedge clk) begin
        exp_t e;
        busy_seen = busy;
        check("level", 32'(level), 32'(fq.size()));
        check("busy", 32'(busy), 32'(fq.size() >= DEPTH - 1));
        check("overflow", 32'(overflow), 32'(ovf_m));
        check("data_out_hold", 32'(data_out), 32'(last_out));
        if (valid_out) begin
            checks++;
            if (eq.size() == 0) begin
                errors++;
                $display("FAIL spurious_valid_out: got data %0d expected no pulse (cycle %0d)", data_out, cyc);
            end else begin
                e = eq.pop_front();
                got_q.push_back(data_out);
                if (e.due != cyc || data_out !== e.d) begin
                    errors++;
                    $display("FAIL completion: got data %0d at cycle %0d expected data %0d at cycle %0d",
                             data_out, cyc, e.d, e.due);
                end
            end
        end else if (eq.size() > 0 && eq[0].due <= cyc) begin
            e = eq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_valid_out: got none expected data %0d at cycle %0d", e.d, e.due);
        end
    end

    task automatic step(input logic v, input logic [DSIZE-1:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        valid_in = 1'b0;
        data_in  = '0;
        rstn     = 1'b0;
        @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((eq.size() > 0 || fq.size() > 0 || proc_left > 0) && n < 300) begin
            step(1'b0, '0);
            n++;
        end
        check("drain_timeout", 32'(n >= 300), 32'd0);
    endtask

    initial begin
        int               lat;
        int               maxl;
        int               busy_lvl;
        int               nd;
        int               mode;
        int               p;
        logic             v;
        logic             ok;
        logic             pulse;
        logic [DSIZE-1:0] exp3 [5];

        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rstn = 1'b1;

        // single word latency
        step(1'b1, 4'hA);
        check("t1_level_after_capture", 32'(level), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, '0);
            if (k == 1) check("t1_level_after_pop", 32'(level), 32'd0);
            if (valid_out && lat == 0) lat = k;
        end
        check("t1_latency_edges", 32'(lat), 32'(PROC_CYCLES + 1));
        check("t1_data", 32'(data_out), 32'hA);

        // invalid words ignored
        pulse = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'hF);
            if (valid_out || level != 0) pulse = 1'b1;
        end
        check("t6_ignored", 32'(pulse), 32'd0);

        // registered requester honouring busy
        reset_dut();
        got_q.delete();
        maxl = 0;
        busy_lvl = -1;
        nd = 1;
        for (int k = 0; k < 40; k++) begin
            v = !busy_seen;
            step(v, v ? DSIZE'(nd) : '0);
            if (v) nd++;
            if (int'(level) > maxl) maxl = int'(level);
            if (busy && busy_lvl < 0) busy_lvl = int'(level);
        end
        drain();
        check("t2_busy_rise_level", 32'(busy_lvl), 32'd3);
        check("t2_max_level", 32'(maxl), 32'd4);
        check("t2_overflow", 32'(overflow), 32'd0);
        ok = (got_q.size() == nd - 1);
        for (int i = 0; i < got_q.size(); i++) begin
            if (got_q[i] != DSIZE'(i + 1)) ok = 1'b0;
        end
        check("t2_order", 32'(ok), 32'd1);

        // forced overflow while the processor is busy with a leading word
        reset_dut();
        got_q.delete();
        step(1'b1, 4'd9);
        for (int i = 0; i < 5; i++) step(1'b1, DSIZE'(i));
        step(1'b0, '0);
        check("t3_overflow_set", 32'(overflow), 32'd1);
        drain();
        check("t3_overflow_sticky", 32'(overflow), 32'd1);
        exp3 = '{4'd9, 4'd0, 4'd1, 4'd2, 4'd3};
        ok = (got_q.size() == 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            if (got_q[i] != exp3[i]) ok = 1'b0;
        end
        check("t3_sequence", 32'(ok), 32'd1);

        // push and pop in the same cycle at full
        reset_dut();
        step(1'b1, 4'd9);
        for (int i = 0; i < 4; i++) step(1'b1, DSIZE'(i));
        step(1'b0, '0);
        check("t4_full_before", 32'(level), 32'd4);
        step(1'b1, 4'd5);
        check("t4_level", 32'(level), 32'd4);
        check("t4_overflow", 32'(overflow), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        drain();

        // reset while a word is in processing
        reset_dut();
        step(1'b1, 4'd1);
        step(1'b1, 4'd2);
        step(1'b1, 4'd3);
        valid_in = 1'b0;
        check("t5_level_before", 32'(level), 32'd2);
        rstn = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_level", 32'(level), 32'd0);
        check("t5_valid_out", 32'(valid_out), 32'd0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        pulse = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, '0);
            if (valid_out) pulse = 1'b1;
        end
        check("t5_no_pulse", 32'(pulse), 32'd0);

        // randomized traffic, mixed requester behaviour, occasional resets
        reset_dut();
        for (int c = 0; c < 30; c++) begin
            mode = $urandom_range(0, 2);
            p    = $urandom_range(20, 90);
            for (int k = 0; k < 50; k++) begin
                if ($urandom_range(0, 399) == 0) reset_dut();
                if (mode == 0) v = !busy_seen && ($urandom_range(0, 99) < p);
                else           v = ($urandom_range(0, 99) < p);
                step(v, v ? DSIZE'($urandom) : '0);
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
